// File: rtl/i2s_tx_ser_pkg.sv
// Shared constants for the I2S transmit serializer: channel-length codes,
// bit-counter width and slot lengths.
package i2s_tx_ser_pkg;

    localparam logic I2S_CHL_16_BITS     = 1'b0;
    localparam logic I2S_CHL_32_BITS     = 1'b1;
    localparam int   I2S_TX_BITCNT_WIDTH = 6;

    localparam logic [I2S_TX_BITCNT_WIDTH-1:0] I2S_TX_SLOT_16 = 6'd16;
    localparam logic [I2S_TX_BITCNT_WIDTH-1:0] I2S_TX_SLOT_32 = 6'd32;

    function automatic logic [I2S_TX_BITCNT_WIDTH-1:0] slot_bits(input logic chl);
        return (chl == I2S_CHL_32_BITS) ? I2S_TX_SLOT_32 : I2S_TX_SLOT_16;
    endfunction

endpackage

// File: rtl/i2s_edge_det.sv
// 1-bit registered copy used for edge detection; parks at the idle level
// while disabled so that enabling never produces a false edge.
module i2s_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic idle,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (!en) begin
            q <= idle;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/i2s_tx_ser.sv
// Philips I2S transmit serializer: one-word holding register, left-aligned
// shift register, MSB one SCK after each ws transition.
module i2s_tx_ser
    import i2s_tx_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  pol_i,
    input  logic                  chl_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  sd_o,
    output logic                  busy_o,
    output logic                  underrun_o
);

    logic                           sck_q;
    logic                           ws_q;
    logic                           tx_edge;
    logic                           ws_edge;
    logic                           push;
    logic                           hold_vld;
    logic [DATA_WIDTH-1:0]          hold_dat;
    logic [DATA_WIDTH-1:0]          shreg;
    logic [I2S_TX_BITCNT_WIDTH-1:0] bitcnt;

    function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] w,
                                                         input logic              chl);
        if (chl == I2S_CHL_16_BITS) begin
            return {w[15:0], {(DATA_WIDTH-16){1'b0}}};
        end
        return w;
    endfunction

    i2s_edge_det #(.RST_VAL(1'b0)) u_sck_det (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (en_i),
        .idle  (pol_i),
        .d     (sck_i),
        .q     (sck_q)
    );

    i2s_edge_det #(.RST_VAL(1'b0)) u_ws_det (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (en_i),
        .idle  (pol_i),
        .d     (ws_i),
        .q     (ws_q)
    );

    // Transmit edge is the return of sck to its idle level.
    assign tx_edge = (sck_q != pol_i) && (sck_i == pol_i);
    assign ws_edge = (ws_q != ws_i);
    // Gated by reset so the FIFO sees no acceptance while the block is held in reset.
    assign ready_o = rst_n_i & en_i & (~hold_vld | ws_edge);
    assign push    = valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_vld <= 1'b0;
        end else if (!en_i) begin
            hold_vld <= 1'b0;
        end else if (push) begin
            hold_vld <= 1'b1;
        end else if (ws_edge) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            hold_dat <= dat_i;
        end
    end

    // A ws edge wins over a coincident tx edge; the MSB leaves on the next tx edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg      <= '0;
            bitcnt     <= '0;
            sd_o       <= 1'b0;
            busy_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            if (!en_i) begin
                bitcnt <= '0;
                sd_o   <= 1'b0;
                busy_o <= 1'b0;
            end else if (ws_edge) begin
                shreg      <= hold_vld ? align_word(hold_dat, chl_i) : '0;
                underrun_o <= ~hold_vld;
                bitcnt     <= slot_bits(chl_i);
                busy_o     <= 1'b1;
                if (tx_edge) begin
                    sd_o <= 1'b0;
                end
            end else if (tx_edge) begin
                if (bitcnt != '0) begin
                    sd_o   <= shreg[DATA_WIDTH-1];
                    shreg  <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt - 6'd1;
                    if (bitcnt == 6'd1) begin
                        busy_o <= 1'b0;
                    end
                end else begin
                    sd_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_ser.sv
// Directed bench for i2s_tx_ser: drives sck/ws like the clock generator,
// feeds words through valid/ready and decodes sd_o on the receive edges.
`timescale 1ns/1ps
module tb_i2s_tx_ser;
    import i2s_tx_ser_pkg::*;

    localparam int HALF     = 2;   // clk cycles per sck half period
    localparam int SLOT_SCK = 36;  // sck periods per channel slot

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        pol   = 1'b0;
    logic        chl   = I2S_CHL_32_BITS;
    logic        sck   = 1'b0;
    logic        ws    = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] dat   = '0;
    logic        ready;
    logic        sd;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rx_word      [16];
    logic        rx_ws        [16];
    logic        rx_extra     [16];
    logic        rx_busy_prev [16];
    logic        rx_busy_last [16];
    logic [31:0] tx_q [$];
    logic        gen_done;
    int          n_acc;
    int          u0;

    int urun_cnt = 0;
    int urun_run = 0;
    int urun_max = 0;

    i2s_tx_ser #(.DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .pol_i      (pol),
        .chl_i      (chl),
        .sck_i      (sck),
        .ws_i       (ws),
        .dat_i      (dat),
        .valid_i    (valid),
        .ready_o    (ready),
        .sd_o       (sd),
        .busy_o     (busy),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (underrun) begin
            urun_run = urun_run + 1;
            if (urun_run == 1) urun_cnt = urun_cnt + 1;
            if (urun_run > urun_max) urun_max = urun_run;
        end else begin
            urun_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic p, input logic c);
        @(negedge clk);
        en = 1'b0; valid = 1'b0; pol = p; chl = c; sck = p; ws = p;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Generator + receiver: ws toggles on the first tx edge of each slot,
    // receive samples taken just before each rx edge.
    task automatic gen_slots(input int nslots, input int nbits, input int abort_k);
        logic [31:0] w;
        logic        ex;
        repeat (4) @(negedge clk);
        for (int s = 0; s < nslots; s++) begin
            w  = '0;
            ex = 1'b0;
            for (int k = 0; k < SLOT_SCK; k++) begin
                @(negedge clk);
                sck = pol;
                if (k == 0) ws = ~ws;
                repeat (HALF - 1) @(negedge clk);
                @(negedge clk);
                if (k >= 1 && k <= nbits) w = {w[30:0], sd};
                else ex = ex | sd;
                if (k == nbits - 1) rx_busy_prev[s] = busy;
                if (k == nbits) rx_busy_last[s] = busy;
                if (s == 0 && k == abort_k) begin
                    gen_done = 1'b1;
                    return;
                end
                sck = ~pol;
                repeat (HALF - 1) @(negedge clk);
            end
            rx_word[s]  = w;
            rx_ws[s]    = ws;
            rx_extra[s] = ex;
        end
        gen_done = 1'b1;
    endtask

    task automatic feed(input int delay, output int acc);
        int idx;
        idx = 0;
        acc = 0;
        repeat (delay) @(negedge clk);
        while (!gen_done) begin
            @(negedge clk);
            if (idx < tx_q.size()) begin
                valid = 1'b1;
                dat   = tx_q[idx];
            end else begin
                valid = 1'b0;
                dat   = '0;
            end
            #3;
            if (valid && ready) begin
                idx++;
                acc++;
            end
        end
        valid = 1'b0;
    endtask

    task automatic run(input int nslots, input int nbits, input int delay, input int abort_k);
        gen_done = 1'b0;
        fork
            gen_slots(nslots, nbits, abort_k);
            feed(delay, n_acc);
        join
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("dis_ready", 32'(ready), 32'd0);

        // 32-bit, pol=0: lead-in right word, then L and R
        setup(1'b0, I2S_CHL_32_BITS);
        tx_q = '{32'h0BAD_F00D, 32'hA5A5_0F0F, 32'h1234_5678};
        u0 = urun_cnt;
        run(3, 32, 0, -1);
        chk("m32_lead", rx_word[0], 32'h0BAD_F00D);
        chk("m32_left", rx_word[1], 32'hA5A5_0F0F);
        chk("m32_left_ws", 32'(rx_ws[1]), 32'd0);
        chk("m32_right", rx_word[2], 32'h1234_5678);
        chk("m32_right_ws", 32'(rx_ws[2]), 32'd1);
        chk("m32_tail_zero", 32'(rx_extra[1]), 32'd0);
        chk("m32_busy_bit31", 32'(rx_busy_prev[1]), 32'd1);
        chk("m32_busy_bit32", 32'(rx_busy_last[1]), 32'd0);
        chk("m32_no_underrun", 32'(urun_cnt - u0), 32'd0);

        // 16-bit mode
        setup(1'b0, I2S_CHL_16_BITS);
        tx_q = '{32'hFFFF_8001, 32'hFFFF_8001};
        run(2, 16, 0, -1);
        chk("m16_word0", rx_word[0], 32'h0000_8001);
        chk("m16_word1", rx_word[1], 32'h0000_8001);
        chk("m16_tail_zero0", 32'(rx_extra[0]), 32'd0);
        chk("m16_tail_zero1", 32'(rx_extra[1]), 32'd0);
        chk("m16_busy_bit15", 32'(rx_busy_prev[1]), 32'd1);
        chk("m16_busy_bit16", 32'(rx_busy_last[1]), 32'd0);

        // Underrun: nothing held at the first ws edge
        setup(1'b0, I2S_CHL_32_BITS);
        tx_q = '{32'hC3C3_3C3C};
        u0 = urun_cnt;
        run(2, 32, 20, -1);
        chk("ur_count", 32'(urun_cnt - u0), 32'd1);
        chk("ur_width", 32'(urun_max), 32'd1);
        chk("ur_slot_zero", rx_word[0], 32'h0);
        chk("ur_slot_zero_tail", 32'(rx_extra[0]), 32'd0);
        chk("ur_next_word", rx_word[1], 32'hC3C3_3C3C);

        // Backpressure: valid held high across 8 words
        setup(1'b0, I2S_CHL_32_BITS);
        tx_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        u0 = urun_cnt;
        run(8, 32, 0, -1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_word%0d", i), rx_word[i], 32'(i));
        end
        chk("bp_accepts", 32'(n_acc), 32'd8);
        chk("bp_no_underrun", 32'(urun_cnt - u0), 32'd0);

        // pol=1: rising-edge transmit, first slot is left
        u0 = urun_cnt;
        setup(1'b1, I2S_CHL_32_BITS);
        chk("p1_en_busy", 32'(busy), 32'd0);
        chk("p1_en_sd", 32'(sd), 32'd0);
        chk("p1_en_ready", 32'(ready), 32'd1);
        tx_q = '{32'hA5A5_0F0F, 32'h1234_5678};
        run(2, 32, 0, -1);
        chk("p1_left", rx_word[0], 32'hA5A5_0F0F);
        chk("p1_left_ws", 32'(rx_ws[0]), 32'd0);
        chk("p1_right", rx_word[1], 32'h1234_5678);
        chk("p1_no_underrun", 32'(urun_cnt - u0), 32'd0);

        // Async reset after 10 bits of a word
        setup(1'b0, I2S_CHL_32_BITS);
        tx_q = '{32'hFFFF_FFFF, 32'h5A5A_C3C3};
        run(1, 32, 0, 10);
        chk("ar_inflight_sd", 32'(sd), 32'd1);
        chk("ar_inflight_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sd", 32'(sd), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'(ready), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        setup(1'b0, I2S_CHL_32_BITS);
        tx_q = '{32'h5A5A_C3C3};
        run(1, 32, 0, -1);
        chk("ar_after_word", rx_word[0], 32'h5A5A_C3C3);
        chk("ar_after_tail", 32'(rx_extra[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
